// File: rtl/flash_pkg.sv
// Shared definitions for the NOR-flash responder.
//   - command opcodes accepted on the strobe bus
//   - status register bit positions
//   - command FSM and read-mode encodings
//   - max_int helper used for counter sizing
package flash_pkg;

    localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;
    localparam logic [7:0] CMD_READ_STATUS = 8'h70;
    localparam logic [7:0] CMD_CLR_STATUS  = 8'h50;
    localparam logic [7:0] CMD_PROG        = 8'h40;
    localparam logic [7:0] CMD_PROG_ALT    = 8'h10;
    localparam logic [7:0] CMD_ERASE       = 8'h20;
    localparam logic [7:0] CMD_CONFIRM     = 8'hD0;

    localparam int ST_READY_BIT     = 7;
    localparam int ST_ERASE_ERR_BIT = 5;
    localparam int ST_PROG_ERR_BIT  = 4;

    typedef enum logic [2:0] {
        S_READY,
        S_PROG_SETUP,
        S_ERASE_SETUP,
        S_PROG_BUSY,
        S_ERASE_BUSY
    } cmd_state_e;

    typedef enum logic {
        MODE_ARRAY,
        MODE_STATUS
    } read_mode_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flash_bus_sync.sv
// Two-flop synchronizer for the asynchronous flash strobe bus.
// Strobes, address and data share one synchronizer so they stay aligned.
// Ports:
//   CLK_50MHZ, RST            clock, synchronous active-high reset
//   nf_*_n, nf_a, nf_d_in     raw pins from the initiator
//   ce_s/oe_s/we_s/rp_s       synchronized strobes (active-low)
//   a_s, d_s                  synchronized address / data
//   we_rise                   one-cycle pulse: we_s 0->1 while ce_s = 0
module flash_bus_sync
    import flash_pkg::*;
(
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       nf_ce_n,
    input  logic       nf_oe_n,
    input  logic       nf_we_n,
    input  logic       nf_rp_n,
    input  logic [7:0] nf_a,
    input  logic [7:0] nf_d_in,
    output logic       ce_s,
    output logic       oe_s,
    output logic       we_s,
    output logic       rp_s,
    output logic [7:0] a_s,
    output logic [7:0] d_s,
    output logic       we_rise
);

    // Bundle layout: {ce, oe, we, rp, a[7:0], d[7:0]}
    localparam int             BW   = 20;
    localparam logic [BW-1:0]  IDLE = {4'b1111, 16'h0000};

    logic [BW-1:0] meta_q, meta_d;
    logic [BW-1:0] sync_q, sync_d;
    logic          we_prev_q, we_prev_d;

    always_comb begin
        meta_d    = {nf_ce_n, nf_oe_n, nf_we_n, nf_rp_n, nf_a, nf_d_in};
        sync_d    = meta_q;
        we_prev_d = sync_q[17];
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            meta_q    <= IDLE;
            sync_q    <= IDLE;
            we_prev_q <= 1'b1;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            we_prev_q <= we_prev_d;
        end
    end

    assign ce_s = sync_q[19];
    assign oe_s = sync_q[18];
    assign we_s = sync_q[17];
    assign rp_s = sync_q[16];
    assign a_s  = sync_q[15:8];
    assign d_s  = sync_q[7:0];

    // Address/data are captured from the same cycle the rise is seen.
    assign we_rise = we_s & ~we_prev_q & ~ce_s;

endmodule

// File: rtl/flash_responder.sv
// On-chip stand-in for a 256-byte Intel-style NOR flash on the strobe bus.
// Ports:
//   CLK_50MHZ, RST      clock, synchronous active-high reset
//   nf_ce_n/oe_n/we_n   bus strobes (async, active-low)
//   nf_rp_n             reset/power-down (async, active-low)
//   nf_a, nf_d_in       byte address, write data
//   nf_d_out, nf_d_oe   read data and its output enable (tristate built above)
//   nf_sts              1 = ready, 0 = busy
module flash_responder
    import flash_pkg::*;
#(
    parameter int         PROG_CYCLES  = 50,
    parameter int         ERASE_CYCLES = 5000,
    parameter logic [7:0] INIT_VAL     = 8'hFF
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       nf_ce_n,
    input  logic       nf_oe_n,
    input  logic       nf_we_n,
    input  logic       nf_rp_n,
    input  logic [7:0] nf_a,
    input  logic [7:0] nf_d_in,
    output logic [7:0] nf_d_out,
    output logic       nf_d_oe,
    output logic       nf_sts
);

    localparam int CNT_W = $clog2(max_int(PROG_CYCLES, ERASE_CYCLES) + 1);

    logic       ce_s, oe_s, we_s, rp_s, we_rise;
    logic [7:0] a_s, d_s;

    flash_bus_sync u_sync (
        .CLK_50MHZ (CLK_50MHZ),
        .RST       (RST),
        .nf_ce_n   (nf_ce_n),
        .nf_oe_n   (nf_oe_n),
        .nf_we_n   (nf_we_n),
        .nf_rp_n   (nf_rp_n),
        .nf_a      (nf_a),
        .nf_d_in   (nf_d_in),
        .ce_s      (ce_s),
        .oe_s      (oe_s),
        .we_s      (we_s),
        .rp_s      (rp_s),
        .a_s       (a_s),
        .d_s       (d_s),
        .we_rise   (we_rise)
    );

    // Power-up content; neither RST nor nf_rp_n touches the array.
    logic [7:0] mem [0:255] = '{default: INIT_VAL};

    cmd_state_e        state_q, state_d;
    read_mode_e        mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        ptr_q, ptr_d;
    logic              walk_q, walk_d;
    logic              sts_q, sts_d;
    logic              erase_err_q, erase_err_d;
    logic              prog_err_q, prog_err_d;
    logic [7:0]        d_out_q, d_out_d;
    logic              d_oe_q, d_oe_d;

    logic              hold;
    logic              busy;
    logic [7:0]        status;
    logic [7:0]        mem_rd;
    logic              mem_we;
    logic [7:0]        mem_waddr;
    logic [7:0]        mem_wdata;

    // nf_rp_n low acts like RST for everything except the array.
    assign hold   = RST | ~rp_s;
    assign busy   = (state_q == S_PROG_BUSY) || (state_q == S_ERASE_BUSY);
    assign mem_rd = mem[a_s];

    always_comb begin
        status                   = 8'h00;
        status[ST_READY_BIT]     = sts_q;
        status[ST_ERASE_ERR_BIT] = erase_err_q;
        status[ST_PROG_ERR_BIT]  = prog_err_q;
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        walk_d      = walk_q;
        sts_d       = sts_q;
        erase_err_d = erase_err_q;
        prog_err_d  = prog_err_q;
        mem_we      = 1'b0;
        mem_waddr   = a_s;
        mem_wdata   = d_s;

        d_oe_d  = ~ce_s & ~oe_s & we_s;
        d_out_d = (busy || mode_q == MODE_STATUS) ? status : mem_rd;

        case (state_q)
            S_READY: begin
                if (we_rise) begin
                    case (d_s)
                        CMD_READ_ARRAY:  mode_d = MODE_ARRAY;
                        CMD_READ_STATUS: mode_d = MODE_STATUS;
                        CMD_CLR_STATUS: begin
                            erase_err_d = 1'b0;
                            prog_err_d  = 1'b0;
                        end
                        CMD_PROG, CMD_PROG_ALT: state_d = S_PROG_SETUP;
                        CMD_ERASE:              state_d = S_ERASE_SETUP;
                        default: ;
                    endcase
                end
            end
            S_PROG_SETUP: begin
                if (we_rise) begin
                    // Programming can only clear bits; asking for a 1 over
                    // a stored 0 is flagged but the AND still happens.
                    mem_we    = 1'b1;
                    mem_waddr = a_s;
                    mem_wdata = mem_rd & d_s;
                    if ((d_s & ~mem_rd) != 8'h00)
                        prog_err_d = 1'b1;
                    state_d = S_PROG_BUSY;
                    mode_d  = MODE_STATUS;
                    sts_d   = 1'b0;
                    cnt_d   = CNT_W'(PROG_CYCLES - 1);
                end
            end
            S_ERASE_SETUP: begin
                if (we_rise) begin
                    mode_d = MODE_STATUS;
                    if (d_s == CMD_CONFIRM) begin
                        state_d = S_ERASE_BUSY;
                        sts_d   = 1'b0;
                        walk_d  = 1'b1;
                        ptr_d   = 8'h00;
                    end else begin
                        erase_err_d = 1'b1;
                        prog_err_d  = 1'b1;
                        state_d     = S_READY;
                    end
                end
            end
            S_PROG_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_READY;
                    sts_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ERASE_BUSY: begin
                if (walk_q) begin
                    // Phase 1: one byte per clock; then the settle countdown.
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = INIT_VAL;
                    ptr_d     = ptr_q + 8'd1;
                    if (ptr_q == 8'hFF) begin
                        walk_d = 1'b0;
                        cnt_d  = CNT_W'(ERASE_CYCLES - 1);
                    end
                end else if (cnt_q == '0) begin
                    state_d = S_READY;
                    sts_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_READY;
        endcase

        if (hold)
            mem_we = 1'b0;
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (hold) begin
            state_q     <= S_READY;
            mode_q      <= MODE_ARRAY;
            cnt_q       <= '0;
            ptr_q       <= 8'h00;
            walk_q      <= 1'b0;
            sts_q       <= 1'b1;
            erase_err_q <= 1'b0;
            prog_err_q  <= 1'b0;
            d_out_q     <= 8'h00;
            d_oe_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            walk_q      <= walk_d;
            sts_q       <= sts_d;
            erase_err_q <= erase_err_d;
            prog_err_q  <= prog_err_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    assign nf_d_out = d_out_q;
    assign nf_d_oe  = d_oe_q;
    assign nf_sts   = sts_q;

endmodule

// File: tb/tb_flash_responder.sv
// Directed testbench for flash_responder: bus reads/writes through the
// asynchronous strobe pins, expected values computed by hand.
module tb_flash_responder;

    logic       CLK_50MHZ = 1'b0;
    logic       RST = 1'b1;
    logic       nf_ce_n = 1'b1, nf_oe_n = 1'b1, nf_we_n = 1'b1, nf_rp_n = 1'b1;
    logic [7:0] nf_a = 8'h00, nf_d_in = 8'h00;
    logic [7:0] nf_d_out;
    logic       nf_d_oe, nf_sts;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_total = 0;

    localparam int ERASE_BUSY = 256 + 5000;

    flash_responder dut (
        .CLK_50MHZ (CLK_50MHZ),
        .RST       (RST),
        .nf_ce_n   (nf_ce_n),
        .nf_oe_n   (nf_oe_n),
        .nf_we_n   (nf_we_n),
        .nf_rp_n   (nf_rp_n),
        .nf_a      (nf_a),
        .nf_d_in   (nf_d_in),
        .nf_d_out  (nf_d_out),
        .nf_d_oe   (nf_d_oe),
        .nf_sts    (nf_sts)
    );

    always #10 CLK_50MHZ = ~CLK_50MHZ;

    // Running count of clock edges seen with nf_sts low.
    always @(posedge CLK_50MHZ)
        if (nf_sts === 1'b0) busy_total <= busy_total + 1;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK_50MHZ);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK_50MHZ);
        nf_a = a; nf_d_in = d; nf_ce_n = 1'b0; nf_we_n = 1'b0;
        idle(3);
        nf_we_n = 1'b1;
        idle(3);
        nf_ce_n = 1'b1;
        idle(2);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge CLK_50MHZ);
        nf_a = a; nf_ce_n = 1'b0; nf_oe_n = 1'b0;
        idle(4);
        d = nf_d_out;
        nf_ce_n = 1'b1; nf_oe_n = 1'b1;
        idle(2);
    endtask

    task automatic wait_ready(input int limit, input string tag);
        int n = 0;
        while (nf_sts !== 1'b1 && n < limit) begin
            @(negedge CLK_50MHZ);
            n++;
        end
        n_cmp++;
        if (nf_sts !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: still busy after %0d cycles, required ready", tag, limit);
        end
    endtask

    task automatic program_byte(input logic [7:0] a, input logic [7:0] d);
        bus_write(8'h00, 8'h40);
        bus_write(a, d);
        wait_ready(200, "program_byte");
    endtask

    task automatic test_reset;
        RST = 1'b1;
        idle(3);
        n_cmp += 3;
        if (nf_sts !== 1'b1) begin n_bad++; $display("FAIL reset_sts: got %b want 1", nf_sts); end
        if (nf_d_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", nf_d_oe); end
        if (nf_d_out !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", nf_d_out); end
        RST = 1'b0;
        idle(3);
        // Pin-to-data latency: not yet after 2 clocks, valid after 3.
        nf_a = 8'h10; nf_ce_n = 1'b0; nf_oe_n = 1'b0;
        idle(2);
        n_cmp++;
        if (nf_d_oe !== 1'b0) begin n_bad++; $display("FAIL latency_early_oe: got %b want 0", nf_d_oe); end
        idle(1);
        n_cmp += 3;
        if (nf_d_oe !== 1'b1) begin n_bad++; $display("FAIL latency_oe: got %b want 1", nf_d_oe); end
        if (nf_d_out !== 8'hFF) begin n_bad++; $display("FAIL latency_dout: got %h want FF", nf_d_out); end
        if (nf_sts !== 1'b1) begin n_bad++; $display("FAIL idle_sts: got %b want 1", nf_sts); end
        nf_ce_n = 1'b1; nf_oe_n = 1'b1;
        idle(3);
    endtask

    task automatic test_program;
        logic [7:0] v;
        int b0;
        b0 = busy_total;
        bus_write(8'h00, 8'h40);
        bus_write(8'h10, 8'h3C);
        bus_read(8'h10, v);
        n_cmp++;
        if (v !== 8'h00) begin n_bad++; $display("FAIL prog_busy_read: got %h want 00", v); end
        wait_ready(200, "prog_ready");
        n_cmp++;
        if (busy_total - b0 !== 50) begin n_bad++; $display("FAIL prog_busy_len: got %0d want 50", busy_total - b0); end
        bus_read(8'h10, v);
        n_cmp++;
        if (v !== 8'h80) begin n_bad++; $display("FAIL prog_status: got %h want 80", v); end
        bus_write(8'h00, 8'hFF);
        bus_read(8'h10, v);
        n_cmp++;
        if (v !== 8'h3C) begin n_bad++; $display("FAIL prog_data: got %h want 3C", v); end
    endtask

    task automatic test_prog_error;
        logic [7:0] v;
        program_byte(8'h10, 8'hF0);
        bus_read(8'h10, v);
        n_cmp++;
        if (v !== 8'h90) begin n_bad++; $display("FAIL prog_err_status: got %h want 90", v); end
        bus_write(8'h00, 8'hFF);
        bus_read(8'h10, v);
        n_cmp++;
        if (v !== 8'h30) begin n_bad++; $display("FAIL prog_and: got %h want 30", v); end
        bus_write(8'h00, 8'h50);
        bus_write(8'h00, 8'h70);
        bus_read(8'h10, v);
        n_cmp++;
        if (v !== 8'h80) begin n_bad++; $display("FAIL clr_status: got %h want 80", v); end
    endtask

    task automatic test_erase;
        logic [7:0] v;
        int b0;
        program_byte(8'h00, 8'h12);
        program_byte(8'hFF, 8'h34);
        b0 = busy_total;
        bus_write(8'h00, 8'h20);
        bus_write(8'h00, 8'hD0);
        bus_read(8'h00, v);
        n_cmp++;
        if (v !== 8'h00) begin n_bad++; $display("FAIL erase_busy_read: got %h want 00", v); end
        wait_ready(6000, "erase_ready");
        n_cmp++;
        if (busy_total - b0 !== ERASE_BUSY) begin n_bad++; $display("FAIL erase_busy_len: got %0d want %0d", busy_total - b0, ERASE_BUSY); end
        bus_read(8'h00, v);
        n_cmp++;
        if (v !== 8'h80) begin n_bad++; $display("FAIL erase_status: got %h want 80", v); end
        bus_write(8'h00, 8'hFF);
        for (int i = 0; i < 256; i++) begin
            bus_read(i[7:0], v);
            n_cmp++;
            if (v !== 8'hFF) begin n_bad++; $display("FAIL erase_cell[%0d]: got %h want FF", i, v); end
        end
    endtask

    task automatic test_erase_bad_confirm;
        logic [7:0] v;
        int b0;
        program_byte(8'h10, 8'h5A);
        program_byte(8'h80, 8'hA5);
        program_byte(8'hC0, 8'h0F);
        b0 = busy_total;
        bus_write(8'h00, 8'h20);
        bus_write(8'h00, 8'h55);
        bus_read(8'h10, v);
        n_cmp += 2;
        if (v !== 8'hB0) begin n_bad++; $display("FAIL bad_confirm_status: got %h want B0", v); end
        if (busy_total - b0 !== 0) begin n_bad++; $display("FAIL bad_confirm_busy: got %0d want 0", busy_total - b0); end
        bus_write(8'h00, 8'h50);
        bus_write(8'h00, 8'hFF);
        bus_read(8'h10, v);
        n_cmp++;
        if (v !== 8'h5A) begin n_bad++; $display("FAIL bad_confirm_data: got %h want 5A", v); end
    endtask

    task automatic test_rp_mid_erase;
        logic [7:0] v;
        bus_write(8'h00, 8'h20);
        bus_write(8'h00, 8'hD0);
        idle(60);
        // Walk pointer is around 0x40 when rp takes effect.
        nf_rp_n = 1'b0; nf_a = 8'h80; nf_ce_n = 1'b0; nf_oe_n = 1'b0;
        idle(4);
        n_cmp += 2;
        if (nf_sts !== 1'b1) begin n_bad++; $display("FAIL rp_sts: got %b want 1", nf_sts); end
        if (nf_d_oe !== 1'b0) begin n_bad++; $display("FAIL rp_oe: got %b want 0", nf_d_oe); end
        nf_rp_n = 1'b1; nf_ce_n = 1'b1; nf_oe_n = 1'b1;
        idle(3);
        bus_read(8'h10, v);
        n_cmp++;
        if (v !== 8'hFF) begin n_bad++; $display("FAIL rp_low_erased: got %h want FF", v); end
        bus_read(8'h80, v);
        n_cmp++;
        if (v !== 8'hA5) begin n_bad++; $display("FAIL rp_kept_80: got %h want A5", v); end
        bus_read(8'hC0, v);
        n_cmp++;
        if (v !== 8'h0F) begin n_bad++; $display("FAIL rp_kept_C0: got %h want 0F", v); end
        bus_write(8'h00, 8'h70);
        bus_read(8'h00, v);
        n_cmp++;
        if (v !== 8'h80) begin n_bad++; $display("FAIL rp_status: got %h want 80", v); end
    endtask

    task automatic test_ce_high_ignored;
        logic [7:0] v;
        logic [7:0] cmds [3];
        int b0;
        cmds[0] = 8'h70; cmds[1] = 8'h20; cmds[2] = 8'hD0;
        bus_write(8'h00, 8'hFF);
        b0 = busy_total;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_50MHZ);
            nf_a = 8'h80; nf_d_in = cmds[i]; nf_ce_n = 1'b1; nf_we_n = 1'b0;
            idle(3);
            nf_we_n = 1'b1;
            idle(3);
        end
        n_cmp += 2;
        if (nf_sts !== 1'b1) begin n_bad++; $display("FAIL ce_high_sts: got %b want 1", nf_sts); end
        if (busy_total - b0 !== 0) begin n_bad++; $display("FAIL ce_high_busy: got %0d want 0", busy_total - b0); end
        bus_read(8'h80, v);
        n_cmp++;
        if (v !== 8'hA5) begin n_bad++; $display("FAIL ce_high_mode: got %h want A5", v); end
    endtask

    task automatic test_busy_ignore;
        logic [7:0] v;
        int b0;
        b0 = busy_total;
        bus_write(8'h00, 8'h40);
        bus_write(8'h20, 8'h3C);
        bus_write(8'h00, 8'h40);
        bus_write(8'h20, 8'h00);
        bus_write(8'h00, 8'hFF);
        wait_ready(200, "prog_busy_ignore_ready");
        n_cmp++;
        if (busy_total - b0 !== 50) begin n_bad++; $display("FAIL prog_busy_ignore_len: got %0d want 50", busy_total - b0); end
        bus_write(8'h00, 8'hFF);
        bus_read(8'h20, v);
        n_cmp++;
        if (v !== 8'h3C) begin n_bad++; $display("FAIL prog_busy_ignore_data: got %h want 3C", v); end

        b0 = busy_total;
        bus_write(8'h00, 8'h20);
        bus_write(8'h00, 8'hD0);
        bus_write(8'h00, 8'h40);
        bus_write(8'h05, 8'h00);
        bus_write(8'h00, 8'hFF);
        wait_ready(6000, "erase_busy_ignore_ready");
        n_cmp++;
        if (busy_total - b0 !== ERASE_BUSY) begin n_bad++; $display("FAIL erase_busy_ignore_len: got %0d want %0d", busy_total - b0, ERASE_BUSY); end
        bus_write(8'h00, 8'hFF);
        bus_read(8'h05, v);
        n_cmp++;
        if (v !== 8'hFF) begin n_bad++; $display("FAIL erase_busy_ignore_05: got %h want FF", v); end
        bus_read(8'h20, v);
        n_cmp++;
        if (v !== 8'hFF) begin n_bad++; $display("FAIL erase_busy_ignore_20: got %h want FF", v); end
    endtask

    initial begin
        test_reset();
        test_program();
        test_prog_error();
        test_erase();
        test_erase_bad_confirm();
        test_rp_mid_erase();
        test_ce_high_ignored();
        test_busy_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flash_responder.md
Name: flash_responder

Overview:
- Synthesizable responder for the 8-bit NOR-flash strobe bus that the flash bridge drives (NF_CE/NF_OE/NF_WE/NF_RP, NF_A, NF_D).
- Emulates a 256-byte Intel-style command-set flash in internal RAM, with a reduced command set.
- Use: on-chip stand-in for the physical flash. Lets the bridge and its clients run in simulation and on hardware without touching the real part.
- Drives NF_STS (ready/busy) back to the initiator.

Parameters:
- PROG_CYCLES, 50: clock cycles a byte program stays busy (1 us @ 50 MHz).
- ERASE_CYCLES, 5000: extra busy cycles after the 256-byte erase walk completes.
- INIT_VAL, 8'hFF: memory content after power-up and after erase.

Ports:
- CLK_50MHZ  in  1  system clock
- RST  in  1  reset: synchronous, active-high
- nf_ce_n  in  1  chip enable, active-low, asynchronous to clock
- nf_oe_n  in  1  output enable, active-low, asynchronous
- nf_we_n  in  1  write enable, active-low, asynchronous
- nf_rp_n  in  1  reset/power-down, active-low, asynchronous
- nf_a  in  8  byte address
- nf_d_in  in  8  data bus, input side
- nf_d_out  out  8  data bus, output value
- nf_d_oe  out  1  data bus output enable; top level builds the tristate
- nf_sts  out  1  1 = ready, 0 = busy

Behaviour:
- Reset: on RST, all of the following, and memory is not cleared:
  - nf_d_out=0, nf_d_oe=0, nf_sts=1
  - status=8'h80, read mode ARRAY, cmd state READY
- Synchronization: nf_ce_n, nf_oe_n, nf_we_n, nf_rp_n, nf_a and nf_d_in all pass through the same 2-flop synchronizer, so they stay aligned. "_s" below denotes the synchronized copies.
- Read path:
  - nf_d_oe = !ce_s & !oe_s & we_s (registered).
  - nf_d_out is registered each cycle from ARRAY ? mem[a_s] : status.
  - While busy, status is returned regardless of mode.
  - Pin-to-data latency is 3 clocks.
- Write strobe: a write is the cycle where we_s goes 0->1 while ce_s=0. It captures a_s and d_s from that cycle. We_s rising with ce_s=1 is ignored.
- Command FSM states: READY, PROG_SETUP, ERASE_SETUP, PROG_BUSY, ERASE_BUSY.
  - READY + write 8'hFF: mode ARRAY.
  - READY + write 8'h70: mode STATUS.
  - READY + write 8'h50: clear status bits 5 and 4.
  - READY + write 8'h40 or 8'h10: go to PROG_SETUP.
  - READY + write 8'h20: go to ERASE_SETUP.
  - READY + any other value: ignored.
  - PROG_SETUP + write: mem[a] <= mem[a] & d. Programming only clears bits; a 1 over a stored 0 sets status bit4. Then go to PROG_BUSY, mode STATUS, nf_sts=0, counter=PROG_CYCLES-1.
  - PROG_BUSY: counter decrements each cycle. At 0, go to READY and set nf_sts=1.
  - ERASE_SETUP + write 8'hD0: go to ERASE_BUSY, mode STATUS, nf_sts=0.
  - ERASE_SETUP + any other value: set status bit5 and bit4, go to READY, mode STATUS.
  - ERASE_BUSY phase 1: an 8-bit pointer writes INIT_VAL to addresses 0..255, one per clock.
  - ERASE_BUSY phase 2: counts ERASE_CYCLES, then goes to READY and sets nf_sts=1.
  - Total erase busy time: 256+ERASE_CYCLES cycles.
  - PROG_BUSY / ERASE_BUSY + write: ignored, with no queuing.
- Status register: bit7 = ready (mirrors nf_sts); bit5 = erase error; bit4 = program error; bits 6 and 3..0 read 0.
- nf_rp_n: while rp_s=0, the block behaves as RST, except memory is kept, including a partially erased array. Also nf_d_oe=0.
- Simultaneous events: RST and rp_s have priority over strobes. An erase-walk write and a program write can never coincide, since programming is only accepted in READY.
- Widths: the address wraps naturally at 8 bits. The counter is wide enough for max(PROG_CYCLES, ERASE_CYCLES).

Decomposition:
- Shared package flash_pkg holds:
  - command opcodes (CMD_READ_ARRAY=FF, CMD_READ_STATUS=70, CMD_CLR_STATUS=50, CMD_PROG=40, CMD_PROG_ALT=10, CMD_ERASE=20, CMD_CONFIRM=D0)
  - status bit indices
  - FSM state encodings
- One sub-module: flash_bus_sync (2-flop synchronizer of strobes, address and data, plus we-rise detect).
- Memory is an inferred 256x8 RAM inside flash_responder.

Test Plan:
- Reset, then read addr 8'h10 (ce=0, oe=0) -> nf_d_oe=1 and nf_d_out=8'hFF after 3 clocks; nf_sts=1.
- Write 40 then write D=8'h3C@8'h10 -> nf_sts=0 for exactly 50 cycles, reads return 8'h00 while busy and 8'h80 once ready; write FF, read 8'h10 -> 8'h3C.
- Program 8'hF0 over 8'h3C at 8'h10 -> mem=8'h30 and status=8'h90; write 50 -> status=8'h80.
- Write 20, write D0 -> busy for 256+ERASE_CYCLES cycles; afterwards addresses 0..255 read 8'hFF in ARRAY mode.
- Write 20, write 8'h55 -> status=8'hB0 and no erase; a mid-erase pulse of nf_rp_n low -> nf_sts=1, mode ARRAY, and addresses below the walk pointer read FF while the rest are unchanged.
- A WE pulse with ce=1 and any data -> no state change; the write commands issued while busy (PROG_BUSY and ERASE_BUSY) are ignored and the busy time is unchanged.
